bit_serializer: RTL and testbench

BIT_SERIALIZER -- requirements
Module: bit_serializer

---
 rtl/bit_serializer.sv | 131 +++++++++++++
 tb/tb_bit_serializer.sv | 187 ++++++++++++++++++
 2 files changed

// File: rtl/bit_serializer.sv
// bit_serializer: parallel-in, serial-out frame shifter with idle gap.
// Registered outputs, IDLE/SHIFT/GAP control, async active-high reset.
module bit_serializer #(
    parameter int WIDTH      = 8,
    parameter bit MSB_FIRST  = 1'b1,
    parameter int GAP_CYCLES = 2,
    parameter bit IDLE_LEVEL = 1'b0
) (
    input  logic             clk,
    input  logic             reset,
    input  logic [WIDTH-1:0] data_in,
    input  logic             load_valid,
    output logic             load_ready,
    output logic             w_out,
    output logic             bit_valid,
    output logic             frame_done
);

    localparam int CW = $clog2(WIDTH) + 1;

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_SHIFT = 2'd1,
        S_GAP   = 2'd2
    } state_t;

    state_t           state_q, state_d;
    logic [WIDTH-1:0] sreg_q, sreg_d;
    logic [CW-1:0]    cnt_q, cnt_d, cnt_nx;
    logic [3:0]       gap_q, gap_d;
    logic             w_out_q, w_out_d;
    logic             bit_valid_q, bit_valid_d;
    logic             frame_done_q, frame_done_d;
    logic             load_ready_q, load_ready_d;

    // Next-state and next-output decode; outputs are computed one cycle
    // ahead so every port comes straight from a flop.
    always_comb begin
        state_d      = state_q;
        sreg_d       = sreg_q;
        cnt_d        = cnt_q;
        gap_d        = gap_q;
        cnt_nx       = cnt_q + 1'b1;
        w_out_d      = IDLE_LEVEL;
        bit_valid_d  = 1'b0;
        frame_done_d = 1'b0;
        load_ready_d = 1'b0;
        case (state_q)
            S_IDLE: begin
                load_ready_d = 1'b1;
                if (load_valid && load_ready_q) begin
                    state_d      = S_SHIFT;
                    sreg_d       = data_in;
                    cnt_d        = '0;
                    bit_valid_d  = 1'b1;
                    load_ready_d = 1'b0;
                    w_out_d      = MSB_FIRST ? data_in[WIDTH-1]
                                             : data_in[0];
                end
            end
            S_SHIFT: begin
                if (cnt_q == CW'(WIDTH - 1)) begin
                    cnt_d = '0;
                    gap_d = '0;
                    if (GAP_CYCLES == 0) begin
                        state_d      = S_IDLE;
                        load_ready_d = 1'b1;
                    end else begin
                        state_d = S_GAP;
                    end
                end else begin
                    cnt_d        = cnt_nx;
                    bit_valid_d  = 1'b1;
                    frame_done_d = (cnt_nx == CW'(WIDTH - 1));
                    if (MSB_FIRST) begin
                        sreg_d  = sreg_q << 1;
                        w_out_d = sreg_q[WIDTH-2];
                    end else begin
                        sreg_d  = sreg_q >> 1;
                        w_out_d = sreg_q[1];
                    end
                end
            end
            S_GAP: begin
                if (gap_q == 4'(GAP_CYCLES - 1)) begin
                    state_d      = S_IDLE;
                    gap_d        = '0;
                    load_ready_d = 1'b1;
                end else begin
                    gap_d = gap_q + 4'd1;
                end
            end
            default: begin
                state_d      = S_IDLE;
                sreg_d       = '0;
                cnt_d        = '0;
                gap_d        = '0;
                load_ready_d = 1'b1;
            end
        endcase
    end

    // State and registered outputs; reset aborts any frame in flight.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q      <= S_IDLE;
            sreg_q       <= '0;
            cnt_q        <= '0;
            gap_q        <= '0;
            w_out_q      <= IDLE_LEVEL;
            bit_valid_q  <= 1'b0;
            frame_done_q <= 1'b0;
            load_ready_q <= 1'b1;
        end else begin
            state_q      <= state_d;
            sreg_q       <= sreg_d;
            cnt_q        <= cnt_d;
            gap_q        <= gap_d;
            w_out_q      <= w_out_d;
            bit_valid_q  <= bit_valid_d;
            frame_done_q <= frame_done_d;
            load_ready_q <= load_ready_d;
        end
    end

    assign w_out      = w_out_q;
    assign bit_valid  = bit_valid_q;
    assign frame_done = frame_done_q;
    assign load_ready = load_ready_q;

endmodule

// File: tb/tb_bit_serializer.sv
// tb_bit_serializer: directed vectors for bit_serializer in four
// parameterisations (defaults, LSB-first, no gap, idle-high).
module tb_bit_serializer;

    logic clk;
    logic rst, rst_a;

    logic [7:0] d_a, d_b, d_c, d_d;
    logic       lv_a, lv_b, lv_c, lv_d;
    logic       rdy_a, rdy_b, rdy_c, rdy_d;
    logic       w_a, w_b, w_c, w_d;
    logic       bv_a, bv_b, bv_c, bv_d;
    logic       fd_a, fd_b, fd_c, fd_d;

    int n_vec = 0;
    int n_err = 0;

    bit_serializer u_a (
        .clk(clk), .reset(rst_a), .data_in(d_a), .load_valid(lv_a),
        .load_ready(rdy_a), .w_out(w_a), .bit_valid(bv_a),
        .frame_done(fd_a)
    );

    bit_serializer #(.MSB_FIRST(1'b0)) u_b (
        .clk(clk), .reset(rst), .data_in(d_b), .load_valid(lv_b),
        .load_ready(rdy_b), .w_out(w_b), .bit_valid(bv_b),
        .frame_done(fd_b)
    );

    bit_serializer #(.GAP_CYCLES(0)) u_c (
        .clk(clk), .reset(rst), .data_in(d_c), .load_valid(lv_c),
        .load_ready(rdy_c), .w_out(w_c), .bit_valid(bv_c),
        .frame_done(fd_c)
    );

    bit_serializer #(.IDLE_LEVEL(1'b1)) u_d (
        .clk(clk), .reset(rst), .data_in(d_d), .load_valid(lv_d),
        .load_ready(rdy_d), .w_out(w_d), .bit_valid(bv_d),
        .frame_done(fd_d)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] got,
                       input logic [31:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    function automatic logic [7:0] stim(input int e);
        return 8'(8'h3C ^ (e * 37));
    endfunction

    logic [7:0] exp_bits;
    logic [7:0] frm;

    initial begin
        rst = 1'b1; rst_a = 1'b1;
        d_a = '0; d_b = '0; d_c = '0; d_d = '0;
        lv_a = 0; lv_b = 0; lv_c = 0; lv_d = 0;

        // reset state, before any clock edge
        #3;
        chk("rst_w",   w_a,   0);
        chk("rst_bv",  bv_a,  0);
        chk("rst_fd",  fd_a,  0);
        chk("rst_rdy", rdy_a, 1);
        chk("rst_w_d", w_d,   1);
        tick(); tick();
        rst = 1'b0; rst_a = 1'b0;
        tick();

        // defaults: 8'hA5 MSB first, 2 gap cycles
        exp_bits = 8'hA5;
        d_a = 8'hA5; lv_a = 1;
        tick();
        lv_a = 0; d_a = 8'h00;
        for (int i = 0; i < 8; i++) begin
            chk("a5_w",   w_a,   exp_bits[7-i]);
            chk("a5_bv",  bv_a,  1);
            chk("a5_fd",  fd_a,  i == 7);
            chk("a5_rdy", rdy_a, 0);
            tick();
        end
        for (int i = 0; i < 2; i++) begin
            chk("gap_w",   w_a,   0);
            chk("gap_bv",  bv_a,  0);
            chk("gap_rdy", rdy_a, 0);
            tick();
        end
        chk("c11_rdy", rdy_a, 1);
        chk("c11_bv",  bv_a,  0);

        // held load_valid, data changing each cycle: period 11
        lv_a = 1;
        for (int e = 0; e < 33; e++) begin
            d_a = stim(e);
            tick();
            frm = stim(11 * (e / 11));
            if ((e % 11) < 8) begin
                chk("bb_w",  w_a,  frm[7-(e%11)]);
                chk("bb_bv", bv_a, 1);
                chk("bb_fd", fd_a, (e % 11) == 7);
            end else begin
                chk("bb_bv",  bv_a,  0);
                chk("bb_rdy", rdy_a, (e % 11) == 10);
            end
        end
        lv_a = 0;
        tick();

        // async reset mid-frame during bit 4
        d_a = 8'hFF; lv_a = 1;
        tick();
        lv_a = 0;
        tick(); tick(); tick();
        chk("b4_w",  w_a,  1);
        chk("b4_bv", bv_a, 1);
        #3 rst_a = 1'b1;
        #1;
        chk("ar_w",   w_a,   0);
        chk("ar_bv",  bv_a,  0);
        chk("ar_rdy", rdy_a, 1);
        chk("ar_fd",  fd_a,  0);
        #1 rst_a = 1'b0;
        for (int i = 0; i < 12; i++) begin
            tick();
            chk("ab_fd", fd_a, 0);
            chk("ab_bv", bv_a, 0);
        end

        // LSB first, 8'h01
        d_b = 8'h01; lv_b = 1;
        tick();
        lv_b = 0;
        for (int i = 0; i < 8; i++) begin
            chk("lsb_w",  w_b,  i == 0);
            chk("lsb_bv", bv_b, 1);
            chk("lsb_fd", fd_b, i == 7);
            tick();
        end
        chk("lsb_gbv", bv_b, 0);

        // no gap, back-to-back FF then 00
        d_c = 8'hFF; lv_c = 1;
        tick();
        d_c = 8'h00;
        for (int c = 1; c <= 17; c++) begin
            if (c <= 8) begin
                chk("ng_w1",  w_c,  1);
                chk("ng_bv1", bv_c, 1);
                chk("ng_fd1", fd_c, c == 8);
            end else if (c == 9) begin
                chk("ng_iw",  w_c,   0);
                chk("ng_ibv", bv_c,  0);
                chk("ng_ird", rdy_c, 1);
            end else begin
                chk("ng_w0",  w_c,  0);
                chk("ng_bv0", bv_c, 1);
                chk("ng_fd0", fd_c, c == 17);
            end
            if (c == 17) lv_c = 0;
            tick();
        end

        // idle-high, never loaded
        for (int i = 0; i < 20; i++) begin
            chk("ih_w",  w_d,  1);
            chk("ih_bv", bv_d, 0);
            tick();
        end

        $display("== %0d vectors applied, %0d miscompares ==",
                 n_vec, n_err);
        $finish;
    end

endmodule
